// File: rtl/snake_pkg.sv
// Shared types and constants for the snake engine: direction codes, game states, palettes
// and cell-coordinate width helper.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef struct packed {
        logic [11:0] bg;
        logic [11:0] grid;
        logic [11:0] border;
        logic [11:0] apple;
        logic [11:0] head;
        logic [11:0] body_even;
        logic [11:0] body_odd;
    } palette_t;

    localparam logic [11:0] COL_OVER = 12'h800;

    localparam palette_t PAL_EARTH = '{bg: 12'h431, grid: 12'h542, border: 12'h753,
                                       apple: 12'hE21, head: 12'hC82,
                                       body_even: 12'hA61, body_odd: 12'h850};

    localparam palette_t PAL_GREEN = '{bg: 12'h020, grid: 12'h040, border: 12'h2A2,
                                       apple: 12'hF30, head: 12'hEF4,
                                       body_even: 12'h6D3, body_odd: 12'h3A1};

    function automatic int unsigned cell_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Direction codes are arranged so the reverse of any direction differs in bit 1 only.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction

endpackage

// File: rtl/snake_pixel_shade.sv
// Registered pixel colour stage: resolves object priority for one pixel per clock.
// SNAKE_WRAP_EN suppresses the border ring.
module snake_pixel_shade
    import snake_pkg::*;
#(
    parameter int unsigned CELL_PX = 20,
    parameter int unsigned GRID_W  = 32,
    parameter int unsigned GRID_H  = 24,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               di,
    input  logic [MAX_LEN-1:1] body_hit,
    input  logic               apple_hit,
    input  logic               head_hit,
    input  state_t             state,
    input  logic               palette,
    output logic [3:0]         r,
    output logic [3:0]         g,
    output logic [3:0]         b
);

    palette_t    pal;
    logic        in_field, grid_line, border, body_odd;
    logic [11:0] col_d, col_q;

    always_comb begin
        pal       = palette ? PAL_GREEN : PAL_EARTH;
        in_field  = (32'(x) < GRID_W * CELL_PX) && (32'(y) < GRID_H * CELL_PX);
        grid_line = (32'(x) % CELL_PX == 0) || (32'(y) % CELL_PX == 0);
`ifdef SNAKE_WRAP_EN
        border = 1'b0;
`else
        border = (32'(x) < CELL_PX) || (32'(x) / CELL_PX == GRID_W - 1) ||
                 (32'(y) < CELL_PX) || (32'(y) / CELL_PX == GRID_H - 1);
`endif
        body_odd = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (i % 2 == 1) body_odd = body_odd | body_hit[i];
        end

        if (!di)                col_d = 12'h000;
        else if (state == OVER) col_d = COL_OVER;
        else if (!in_field)     col_d = 12'h000;
        else if (apple_hit)     col_d = pal.apple;
        else if (head_hit)      col_d = pal.head;
        else if (|body_hit)     col_d = body_odd ? pal.body_odd : pal.body_even;
        else if (border)        col_d = pal.border;
        else if (grid_line)     col_d = pal.grid;
        else                    col_d = pal.bg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) col_q <= 12'h000;
        else          col_q <= col_d;
    end

    assign r = col_q[11:8];
    assign g = col_q[7:4];
    assign b = col_q[3:0];

endmodule

// File: rtl/snake_core.sv
// Snake game engine: circular-buffer body, move/grow/collision FSM and pixel hit detection.
// Define SNAKE_WRAP_EN to make the playfield edges wrap instead of killing the snake.
module snake_core
    import snake_pkg::*;
#(
    parameter int unsigned CELL_PX  = 20,
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      move_tick,
    input  logic [1:0]                dir_in,
    input  logic                      start,
    input  logic [cell_w(GRID_W)-1:0] apple_cx,
    input  logic [cell_w(GRID_H)-1:0] apple_cy,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      di,
    input  logic                      palette,
    output logic [cell_w(GRID_W)-1:0] head_cx,
    output logic [cell_w(GRID_H)-1:0] head_cy,
    output logic [3:0]                r,
    output logic [3:0]                g,
    output logic [3:0]                b,
    output logic [7:0]                score,
    output logic                      eaten,
    output logic                      game_over
);

    localparam int unsigned XW = cell_w(GRID_W);
    localparam int unsigned YW = cell_w(GRID_H);
    localparam int unsigned PW = cell_w(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    state_t        state_q, state_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [PW-1:0] hp_q, hp_nxt;
    logic [LW-1:0] len_q;
    logic [1:0]    dir_q, dir_d, pend_q, pend_d;
    logic [7:0]    score_q;
    logic          eaten_q;

    logic          mv, reload, advance, out_of_grid, self_hit, ate, grows;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    int            sx, sy, lim;

    // Buffer slot holding segment i (segment 0 is the head).
    function automatic logic [PW-1:0] seg_idx(input logic [PW-1:0] hp, input int unsigned i);
        return PW'((32'(hp) + MAX_LEN - i) % MAX_LEN);
    endfunction

    assign head_cx   = seg_x_q[hp_q];
    assign head_cy   = seg_y_q[hp_q];
    assign score     = score_q;
    assign eaten     = eaten_q;
    assign game_over = (state_q == OVER);

    always_comb begin
        mv     = move_tick && (state_q == RUN);
        dir_d  = mv ? pend_q : dir_q;
        pend_d = (dir_in == dir_opposite(dir_d)) ? pend_q : dir_in;
        hp_nxt = seg_idx(hp_q, MAX_LEN - 1);

        sx = int'(head_cx);
        sy = int'(head_cy);
        case (dir_d)
            DIR_UP:   sy = sy - 1;
            DIR_LEFT: sx = sx - 1;
            DIR_DOWN: sy = sy + 1;
            default:  sx = sx + 1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (sx < 0) sx = int'(GRID_W) - 1;
        else if (sx >= int'(GRID_W)) sx = 0;
        if (sy < 0) sy = int'(GRID_H) - 1;
        else if (sy >= int'(GRID_H)) sy = 0;
        out_of_grid = 1'b0;
`else
        out_of_grid = (sx < 0) || (sx >= int'(GRID_W)) || (sy < 0) || (sy >= int'(GRID_H));
`endif
        nx    = XW'(sx);
        ny    = YW'(sy);
        ate   = !out_of_grid && (nx == apple_cx) && (ny == apple_cy);
        grows = ate && (len_q < LW'(MAX_LEN));

        // The tail vacates this cycle unless the body grows, so it cannot be hit.
        lim      = grows ? int'(len_q) : int'(len_q) - 1;
        self_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (int'(i) < lim && seg_x_q[seg_idx(hp_q, i)] == nx &&
                seg_y_q[seg_idx(hp_q, i)] == ny) begin
                self_hit = 1'b1;
            end
        end
        advance = mv && !out_of_grid && !self_hit;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (mv && !advance) state_d = OVER;
            OVER:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        reload = (state_q == OVER) && !start;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || reload) begin
            state_q <= reset_n ? state_d : IDLE;
            hp_q    <= PW'(INIT_LEN - 1);
            len_q   <= LW'(INIT_LEN);
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            score_q <= 8'd0;
            eaten_q <= 1'b0;
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                seg_x_q[k] <= (k < INIT_LEN) ? XW'(GRID_W / 2 + k - (INIT_LEN - 1)) : '0;
                seg_y_q[k] <= YW'(GRID_H / 2);
            end
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            eaten_q <= advance && ate;
            if (advance) begin
                hp_q            <= hp_nxt;
                seg_x_q[hp_nxt] <= nx;
                seg_y_q[hp_nxt] <= ny;
                if (grows) len_q <= len_q + LW'(1);
                if (ate && score_q != 8'hFF) score_q <= score_q + 8'd1;
            end
        end
    end

    logic [9:0]         px_cx, px_cy;
    logic               apple_hit, head_hit;
    logic [MAX_LEN-1:1] body_hit;

    always_comb begin
        px_cx     = x / 10'(CELL_PX);
        px_cy     = y / 10'(CELL_PX);
        apple_hit = (px_cx == 10'(apple_cx)) && (px_cy == 10'(apple_cy));
        head_hit  = (px_cx == 10'(head_cx)) && (px_cy == 10'(head_cy));
        body_hit  = '0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            body_hit[i] = (i < 32'(len_q)) && (10'(seg_x_q[seg_idx(hp_q, i)]) == px_cx) &&
                          (10'(seg_y_q[seg_idx(hp_q, i)]) == px_cy);
        end
    end

    snake_pixel_shade #(
        .CELL_PX(CELL_PX),
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .MAX_LEN(MAX_LEN)
    ) u_shade (
        .clk      (clk),
        .reset_n  (reset_n),
        .x        (x),
        .y        (y),
        .di       (di),
        .body_hit (body_hit),
        .apple_hit(apple_hit),
        .head_hit (head_hit),
        .state    (state_q),
        .palette  (palette),
        .r        (r),
        .g        (g),
        .b        (b)
    );

endmodule
